// File: rtl/npc_pkg.sv
// Shared definitions for the sequential next-PC unit and its return-address stack.
package npc_pkg;

    // Next-PC source encoding; the numeric values are fixed because other blocks decode them.
    typedef enum logic [1:0] {
        SEL_PC4 = 2'd0,
        SEL_BR  = 2'd1,
        SEL_JR  = 2'd2,
        SEL_J   = 2'd3
    } npc_sel_e;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
    localparam int          RAS_DEPTH_DEF = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular LIFO for return addresses. Pushing onto a full stack overwrites the
// oldest entry and raises the sticky ovf flag. Popping an empty stack changes
// nothing except raising the sticky unf flag. pop takes priority over push.
module ras_stack #(
    parameter  int W     = 32,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  top,
    output logic [CW-1:0] count,
    output logic          ovf,
    output logic          unf
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic          full;
    logic          empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Because DEPTH is a power of two, the pointer wraps on its own. This is
    // what lets a push onto a full stack land on the oldest slot.
    assign top = empty ? '0 : mem[ptr - PW'(1)];

    // Entry storage; contents are don't-care until count covers them, so no reset.
    always_ff @(posedge clk) begin
        if (push && !pop)
            mem[ptr] <= din;
    end

    // Pointer, occupancy and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (pop) begin
            if (empty) begin
                unf <= 1'b1;
            end else begin
                ptr   <= ptr - PW'(1);
                count <= count - CW'(1);
            end
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (full)
                ovf <= 1'b1;
            else
                count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/npc_ras.sv
// Sequential next-PC unit. It holds the PC register and selects the next PC from
// branch, jr, jal or pc+4. A return-address stack predicts jr targets: jal pushes
// its link address and jr pops it.
module npc_ras
    import npc_pkg::*;
#(
    parameter  int          ADDR_W    = 32,
    parameter  logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter  int          RAS_DEPTH = RAS_DEPTH_DEF,
    localparam int          CW        = $clog2(RAS_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              br_en,
    input  logic              br_cond,
    input  logic [31:0]       br_off,
    input  logic              jal,
    input  logic              jr,
    input  logic [25:0]       imm26,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc4,
    output logic [ADDR_W-1:0] ras_top,
    output logic [CW-1:0]     ras_count,
    output logic              ras_mispredict,
    output logic              jr_misalign,
    output logic              ras_ovf,
    output logic              ras_unf
);

    npc_sel_e          sel;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] j_tgt;
    logic [31:0]       off_sh;
    logic              push;
    logic              pop;

    assign pc4    = pc + ADDR_W'(4);
    assign off_sh = br_off << 2;
    assign br_tgt = pc4 + off_sh[ADDR_W-1:0];

    // With exactly 28 address bits, no pc4 region bits remain above the jump index.
    if (ADDR_W > 28) begin : g_jreg
        assign j_tgt = {pc4[ADDR_W-1:28], imm26, 2'b00};
    end else begin : g_jflat
        assign j_tgt = {imm26, 2'b00};
    end

    // Source priority: taken branch, then jr, then jal, then fall-through.
    always_comb begin
        sel = SEL_PC4;
        if (br_en && br_cond)
            sel = SEL_BR;
        else if (jr)
            sel = SEL_JR;
        else if (jal)
            sel = SEL_J;
    end

    // Next-PC mux. jr low bits are forced to zero even when misaligned.
    always_comb begin
        target = pc4;
        case (sel)
            SEL_BR:  target = br_tgt;
            SEL_JR:  target = {jr_addr[ADDR_W-1:2], 2'b00};
            SEL_J:   target = j_tgt;
            default: target = pc4;
        endcase
    end

    // Stack actions follow the selected source, so a taken branch suppresses them.
    assign push = !stall && (sel == SEL_J);
    assign pop  = !stall && (sel == SEL_JR);

    // PC register; a stall freezes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC[ADDR_W-1:0];
        else if (!stall)
            pc <= target;
    end

    ras_stack #(
        .W     (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (pc4),
        .top   (ras_top),
        .count (ras_count),
        .ovf   (ras_ovf),
        .unf   (ras_unf)
    );

    // Prediction checks use the raw jr input, independent of stall and branch.
    assign ras_mispredict = jr && ((ras_count == '0) || (ras_top != jr_addr));
    assign jr_misalign    = jr && (jr_addr[1:0] != 2'b00);

endmodule

// File: tb/tb_npc_ras.sv
// Scoreboard bench for npc_ras. The driver applies one instruction per cycle
// just after the rising edge. It pushes the outputs that the reference model
// expects for that cycle, then advances the model. The monitor samples on the
// falling edge and compares each sample with the head of the queue. The model
// keeps the stack as a plain queue of link addresses.
module tb_npc_ras;

    localparam int          ADDR_W = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, br_en = 1'b0, br_cond = 1'b0, jal = 1'b0, jr = 1'b0;
    logic [31:0] br_off = '0;
    logic [25:0] imm26 = '0;
    logic [31:0] jr_addr = '0;
    logic [31:0] pc, pc4, ras_top;
    logic [2:0]  ras_count;
    logic        ras_mispredict, jr_misalign, ras_ovf, ras_unf;

    npc_ras #(.ADDR_W(ADDR_W), .RESET_PC(RST_PC), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_en(br_en), .br_cond(br_cond),
        .br_off(br_off), .jal(jal), .jr(jr), .imm26(imm26), .jr_addr(jr_addr),
        .pc(pc), .pc4(pc4), .ras_top(ras_top), .ras_count(ras_count),
        .ras_mispredict(ras_mispredict), .jr_misalign(jr_misalign),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] pc, pc4, top;
        int          cnt;
        bit          ovf, unf, mis, mal;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    bit          drv_done = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_stk[$];
    bit          m_ovf, m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] m_top();
        return (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 32'h0;
    endfunction

    task automatic model_reset();
        m_pc = RST_PC;
        m_stk.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.pc  = m_pc;
        e.pc4 = m_pc + 32'd4;
        e.top = m_top();
        e.cnt = m_stk.size();
        e.ovf = m_ovf;
        e.unf = m_unf;
        e.mis = jr && (m_stk.size() == 0 || m_top() != jr_addr);
        e.mal = jr && (jr_addr[1:0] != 2'b00);
        exp_q.push_back(e);
    endtask

    // Apply one instruction now (just after an edge), record the expectation,
    // advance the model, then move to just after the next edge.
    task automatic step(input string tag, input bit s, input bit be, input bit bc,
                        input logic [31:0] off, input bit jl, input bit jrr,
                        input logic [25:0] idx, input logic [31:0] ja);
        logic [31:0] l4;
        stall = s; br_en = be; br_cond = bc; br_off = off;
        jal = jl; jr = jrr; imm26 = idx; jr_addr = ja;
        rst_n = 1'b1;
        push_exp(tag);
        l4 = m_pc + 32'd4;
        if (!s) begin
            if (be && bc) begin
                m_pc = l4 + (off * 4);
            end else if (jrr) begin
                m_pc = ja & ~32'd3;
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else m_unf = 1;
            end else if (jl) begin
                m_pc = {l4[31:28], idx, 2'b00};
                m_stk.push_back(l4);
                if (m_stk.size() > DEPTH) begin
                    void'(m_stk.pop_front());
                    m_ovf = 1;
                end
            end else begin
                m_pc = l4;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 32'h0, 0, 0, 26'h0, 32'h0);
    endtask

    // Assert reset between edges. The monitor then checks the reset state
    // before any further clock edge. Release happens just after the next edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        stall = 0; br_en = 0; br_cond = 0; jal = 0; jr = 0;
        model_reset();
        push_exp(tag);
        @(posedge clk); #1;
    endtask

    // Monitor: compare DUT outputs on the falling edge against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.tag, ".pc"},        pc, e.pc);
                chk({e.tag, ".pc4"},       pc4, e.pc4);
                chk({e.tag, ".ras_top"},   ras_top, e.top);
                chk({e.tag, ".ras_count"}, 32'(ras_count), 32'(e.cnt));
                chk({e.tag, ".ovf"},       32'(ras_ovf), 32'(e.ovf));
                chk({e.tag, ".unf"},       32'(ras_unf), 32'(e.unf));
                chk({e.tag, ".mispred"},   32'(ras_mispredict), 32'(e.mis));
                chk({e.tag, ".misalign"},  32'(jr_misalign), 32'(e.mal));
            end
        end
    end

    // Watchdog bound for the whole run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete (got timeout, expected finish)");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk); #1;
        // 1. reset and plain fetch
        do_reset("rst");
        idle("seq0"); idle("seq1"); idle("seq2"); idle("seq3");
        // 2. backward branch taken, then not taken
        do_reset("rst2");
        idle("b0"); idle("b1");
        step("br_tk", 0, 1, 1, 32'hFFFF_FFFE, 0, 0, 26'h0, 32'h0);
        idle("br_after");
        do_reset("rst3");
        idle("b2"); idle("b3");
        step("br_nt", 0, 1, 0, 32'hFFFF_FFFE, 0, 0, 26'h0, 32'h0);
        idle("br_nt_after");
        // 3. call / return
        do_reset("rst4");
        step("call", 0, 0, 0, 32'h0, 1, 0, 26'h0000C10, 32'h0);
        step("ret", 0, 0, 0, 32'h0, 0, 1, 26'h0, 32'h0000_3004);
        idle("ret_after");
        // 4. overflow then drain plus one underflow
        do_reset("rst5");
        for (int i = 0; i < 5; i++)
            step("ovf_jal", 0, 0, 0, 32'h0, 1, 0, 26'h0000C10 + 26'(i * 16), 32'h0);
        for (int i = 0; i < 5; i++)
            step("unf_jr", 0, 0, 0, 32'h0, 0, 1, 26'h0, m_top());
        idle("drain_after");
        // 5. stall, jr+jal priority, branch over jr
        do_reset("rst6");
        step("push1", 0, 0, 0, 32'h0, 1, 0, 26'h0000C10, 32'h0);
        step("stall_jal", 1, 0, 0, 32'h0, 1, 0, 26'h0000D00, 32'h0);
        step("jr_jal", 0, 0, 0, 32'h0, 1, 1, 26'h0000D00, 32'h0000_3004);
        step("push2", 0, 0, 0, 32'h0, 1, 0, 26'h0000C10, 32'h0);
        step("br_jr", 0, 1, 1, 32'h0000_0004, 0, 1, 26'h0, 32'h0000_3044);
        step("stall_jr", 1, 0, 0, 32'h0, 0, 1, 26'h0, 32'h0000_1234);
        idle("prio_after");
        // 6. async reset mid-run, then misaligned jr
        do_reset("rst7");
        step("m_jal0", 0, 0, 0, 32'h0, 1, 0, 26'h0000C10, 32'h0);
        step("m_jal1", 0, 0, 0, 32'h0, 1, 0, 26'h0000C10, 32'h0);
        do_reset("mid_rst");
        step("jr_mal", 0, 0, 0, 32'h0, 0, 1, 26'h0, 32'h0000_3006);
        idle("mal_after");
        // Random phase
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [31:0] ja;
            r  = $urandom_range(0, 99);
            ja = ($urandom_range(0, 1) == 1) ? m_top() : $urandom;
            if (r < 3)
                do_reset("r_rst");
            else
                step("rnd", $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 1) == 1, 32'($urandom_range(0, 63)) - 32'd32,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     26'($urandom), ja);
        end
        drv_done = 1;
        @(negedge clk); @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/npc_ras.md
Name: npc_ras

Overview:
Sequential next-PC unit for the MIPS datapath. It generalises the combinational next-PC logic into three parts:
- an owned PC register with stall support;
- parametrised address width and reset vector;
- a return-address stack (RAS) that predicts jr targets and flags mispredictions.

It sits between the instruction-memory address port and the control/ALU outputs (branch, zero, jal, jr).

Parameters:
ADDR_W, 32, PC width in bits; must be at least 28 and no more than 32.
RESET_PC, 32'h0000_3000, PC value loaded on reset; the low 2 bits must be 0.
RAS_DEPTH, 4, number of RAS entries; a power of two, at least 2.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  1 = hold the PC and the RAS this cycle
br_en  in  1  current instruction is a conditional branch
br_cond  in  1  branch condition true (the ALU zero flag)
br_off  in  32  sign-extended branch offset, in words
jal  in  1  current instruction is jal
jr  in  1  current instruction is jr
imm26  in  26  jump index field
jr_addr  in  ADDR_W  register value used as the jr target
pc  out  ADDR_W  current PC (registered)
pc4  out  ADDR_W  pc + 4, combinational
ras_top  out  ADDR_W  predicted return address; 0 when the RAS is empty
ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries
ras_mispredict  out  1  combinational; 1 when jr is high and (RAS empty or ras_top != jr_addr)
jr_misalign  out  1  combinational; 1 when jr is high and jr_addr[1:0] != 0
ras_ovf  out  1  sticky; set on a push while the RAS is full
ras_unf  out  1  sticky; set on a pop while the RAS is empty

Behaviour:
- Reset (asynchronous, while rst_n = 0):
  - pc = RESET_PC; RAS pointer, ras_count, ras_ovf and ras_unf all = 0.
  - RAS storage contents need not be cleared.
- Next-PC source selection, evaluated combinationally, first match wins:
  1. br_en & br_cond: target = pc4 + (br_off << 2), truncated to ADDR_W (wraps modulo 2^ADDR_W).
  2. jr: target = {jr_addr[ADDR_W-1:2], 2'b00}; low bits are forced to 0 even when jr_misalign = 1.
  3. jal: target = {pc4[ADDR_W-1:28], imm26, 2'b00}.
  4. Otherwise: target = pc4.
- Update: on each rising edge with stall = 0, pc <= target. With stall = 1, pc, the RAS and the sticky flags all hold.
- Latency: the target is visible on pc one cycle after the instruction's control inputs are presented.
- RAS actions, taken only when stall = 0 and the selected source is jr or jal:
  - Branch taken and jal/jr also asserted: branch wins and there is no RAS action.
  - jal push: the entry at the write pointer gets pc4 (the link address); pointer increments modulo RAS_DEPTH.
    - Not full: ras_count increments.
    - Full (ras_count = RAS_DEPTH): the oldest entry is overwritten, ras_count stays at RAS_DEPTH, ras_ovf is set.
  - jr pop, not empty: pointer decrements modulo RAS_DEPTH and ras_count decrements.
  - jr pop, empty: no state change except ras_unf is set.
  - jal and jr both high: jr wins by priority and pops; jal is ignored.
- ras_top is the entry at pointer-1 when ras_count > 0, else 0.
- ras_mispredict and jr_misalign are valid in the same cycle as jr and are independent of stall.
- Sticky flags clear only on reset.
- Reset asserted mid-operation overrides any pending update immediately; the first fetch after rst_n rises is RESET_PC.

Decomposition:
- Package npc_pkg:
  - 2-bit next-PC source encoding: SEL_PC4 = 0, SEL_BR = 1, SEL_JR = 2, SEL_J = 3.
  - Default constants RESET_PC_DEF and RAS_DEPTH_DEF.
- Sub-module ras_stack: a circular LIFO parametrised by width and depth. Ports are push, pop, din, top, count, ovf and unf; the same clk/rst_n convention applies.
- npc_ras contains the source-select mux, the PC register, and the ras_stack instance.

Test Plan:
1. Reset then 3 unstalled cycles with no control -> pc sequence 0x3000, 0x3004, 0x3008, 0x300C; ras_count = 0.
2. Branch wrap: pc = 0x3008, br_en = 1, br_cond = 1, br_off = 0xFFFF_FFFE -> pc = 0x3004. Same inputs with br_cond = 0 -> pc = 0x300C.
3. Call/return: jal with imm26 = 0x0000C10 at pc = 0x3000 -> pc = 0x0000_3040, ras_top = 0x3004, ras_count = 1. Then jr with jr_addr = 0x3004 -> ras_mispredict = 0, pc = 0x3004, ras_count = 0.
4. Overflow: RAS_DEPTH = 4, five consecutive jal from pc 0x3000 / 0x3040 / ... -> ras_count = 4, ras_ovf = 1. Four pops return the last four link addresses in LIFO order; a fifth pop sets ras_unf = 1 and leaves ras_count = 0.
5. Stall and priority:
   - stall = 1 with jal asserted -> pc and ras_count unchanged.
   - jr and jal both high -> pop occurs, no push.
   - br taken with jr high -> branch target used, no pop.
6. Async reset mid-run: assert rst_n = 0 between clock edges at pc = 0x3040 with ras_count = 2 -> pc = 0x3000 and ras_count = 0 immediately, with no clock edge required; jr_addr = 0x3006 then gives jr_misalign = 1 and next pc = 0x3004.
